// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative multiply/divide unit producing HI/LO write data.
// One shift-add (multiply) or restoring (divide) step per cycle, fixed
// latency regardless of operands. Signed forms work on magnitudes and fix
// the signs in the final cycle.
// Build option: define MULDIV_DIV_EN to compile in the divide datapath
// (DIV/DIVU and the DivZero flag). Without it, divide requests are ignored.
module mul_div_unit #(
  parameter int DATA_SIZE = 32
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 Start,
  input  logic [1:0]           Op,
  input  logic [DATA_SIZE-1:0] A,
  input  logic [DATA_SIZE-1:0] B,
  output logic                 Busy,
  output logic [DATA_SIZE-1:0] HiData,
  output logic [DATA_SIZE-1:0] LoData,
  output logic                 WrEnable,
  output logic                 DivZero
);

  localparam int W  = DATA_SIZE;
  localparam int CW = $clog2(W + 1);
  // Counter value reached after the last iteration; one more BUSY cycle
  // applies the sign fix-up and loads the result registers.
  localparam logic [CW-1:0] LAST = CW'(W);
  localparam logic [CW-1:0] ONE  = CW'(1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t         state_r;
  state_t         state_nx;
  logic [CW-1:0]  cnt_r;
  logic [2*W-1:0] prod_r;     // {hi accumulator/remainder, multiplier/quotient}
  logic [W-1:0]   opnd_r;     // multiplicand or divisor magnitude
  logic           neg_q_r;    // negate product / quotient at the end
  logic           busy_r;
  logic           wr_en_r;
  logic [W-1:0]   hi_r;
  logic [W-1:0]   lo_r;

  logic           signed_s;
  logic           accept_s;
  logic           last_s;
  logic           finish_s;
  logic [W-1:0]   mag_a_s;
  logic [W-1:0]   mag_b_s;
  logic [W:0]     mul_sum_s;
  logic [2*W-1:0] mul_next_s;
  logic [2*W-1:0] mul_res_s;
  logic [2*W-1:0] step_s;
  logic [W-1:0]   fin_hi_s;
  logic [W-1:0]   fin_lo_s;

`ifdef MULDIV_DIV_EN
  logic           is_div_r;
  logic           neg_r_r;    // remainder takes the dividend's sign
  logic           bzero_r;
  logic [W-1:0]   a_r;        // original dividend, returned as HI on divide by zero
  logic           dz_r;
  logic [W:0]     div_diff_s;
  logic [2*W-1:0] div_next_s;
  logic [W-1:0]   quo_s;
  logic [W-1:0]   rem_s;
`endif

  // Request decode and operand magnitudes for the signed forms.
  always_comb begin
    signed_s = ~Op[0];
    mag_a_s  = (signed_s && A[W-1]) ? -A : A;
    mag_b_s  = (signed_s && B[W-1]) ? -B : B;
`ifdef MULDIV_DIV_EN
    accept_s = Start;
`else
    accept_s = Start & ~Op[1];
`endif
    last_s   = (cnt_r == LAST);
    finish_s = (state_r == BUSY) && last_s;
  end

  // One iteration step and the sign-corrected final result.
  always_comb begin
    mul_sum_s  = {1'b0, prod_r[2*W-1:W]} + (prod_r[0] ? {1'b0, opnd_r} : {(W+1){1'b0}});
    mul_next_s = {mul_sum_s, prod_r[W-1:1]};
    mul_res_s  = neg_q_r ? -prod_r : prod_r;
`ifdef MULDIV_DIV_EN
    div_diff_s = prod_r[2*W-1:W-1] - {1'b0, opnd_r};
    if (!div_diff_s[W]) begin
      div_next_s = {div_diff_s[W-1:0], prod_r[W-2:0], 1'b1};
    end else begin
      div_next_s = {prod_r[2*W-2:0], 1'b0};
    end
    quo_s = neg_q_r ? -prod_r[W-1:0] : prod_r[W-1:0];
    rem_s = neg_r_r ? -prod_r[2*W-1:W] : prod_r[2*W-1:W];
    step_s = is_div_r ? div_next_s : mul_next_s;
    if (is_div_r) begin
      if (bzero_r) begin
        fin_hi_s = a_r;
        fin_lo_s = {W{1'b1}};
      end else begin
        fin_hi_s = rem_s;
        fin_lo_s = quo_s;
      end
    end else begin
      fin_hi_s = mul_res_s[2*W-1:W];
      fin_lo_s = mul_res_s[W-1:0];
    end
`else
    step_s   = mul_next_s;
    fin_hi_s = mul_res_s[2*W-1:W];
    fin_lo_s = mul_res_s[W-1:0];
`endif
  end

  // FSM state register.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_nx = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_nx = BUSY;
        end else begin
          state_nx = IDLE;
        end
      end
      BUSY: begin
        if (last_s) begin
          state_nx = DONE;
        end else begin
          state_nx = BUSY;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Operand capture and per-cycle iteration of the accumulator.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      cnt_r    <= {CW{1'b0}};
      prod_r   <= {(2*W){1'b0}};
      opnd_r   <= {W{1'b0}};
      neg_q_r  <= 1'b0;
`ifdef MULDIV_DIV_EN
      is_div_r <= 1'b0;
      neg_r_r  <= 1'b0;
      bzero_r  <= 1'b0;
      a_r      <= {W{1'b0}};
`endif
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            cnt_r    <= {CW{1'b0}};
            prod_r   <= {{W{1'b0}}, (Op[1] ? mag_a_s : mag_b_s)};
            opnd_r   <= Op[1] ? mag_b_s : mag_a_s;
            neg_q_r  <= signed_s & (A[W-1] ^ B[W-1]);
`ifdef MULDIV_DIV_EN
            is_div_r <= Op[1];
            neg_r_r  <= signed_s & A[W-1];
            bzero_r  <= (B == {W{1'b0}});
            a_r      <= A;
`endif
          end
        end
        BUSY: begin
          if (!last_s) begin
            prod_r <= step_s;
            cnt_r  <= cnt_r + ONE;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Registered outputs: busy flag, write pulse and held result.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      busy_r  <= 1'b0;
      wr_en_r <= 1'b0;
      hi_r    <= {W{1'b0}};
      lo_r    <= {W{1'b0}};
`ifdef MULDIV_DIV_EN
      dz_r    <= 1'b0;
`endif
    end else begin
      busy_r  <= (state_nx != IDLE);
      wr_en_r <= finish_s;
`ifdef MULDIV_DIV_EN
      dz_r    <= finish_s && is_div_r && bzero_r;
`endif
      if (finish_s) begin
        hi_r <= fin_hi_s;
        lo_r <= fin_lo_s;
      end
    end
  end

  assign Busy     = busy_r;
  assign WrEnable = wr_en_r;
  assign HiData   = hi_r;
  assign LoData   = lo_r;
`ifdef MULDIV_DIV_EN
  assign DivZero  = dz_r;
`else
  assign DivZero  = 1'b0;
`endif

endmodule

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 SHALL have parameter: DATA_SIZE, default 32, operand/result width; only 32 is required to be supported.
REQ-002 SHALL have port: Clk  input  1  rising-edge clock.
REQ-003 SHALL have port: Rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: Start  input  1  request; sampled only in IDLE.
REQ-005 SHALL have port: Op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with Start.
REQ-006 SHALL have port: A  input  DATA_SIZE  multiplicand/dividend; sampled with Start.
REQ-007 SHALL have port: B  input  DATA_SIZE  multiplier/divisor; sampled with Start.
REQ-008 SHALL have port: Busy  output  1  high in BUSY and DONE.
REQ-009 SHALL have port: HiData  output  DATA_SIZE  WriteData for the HI register.
REQ-010 SHALL have port: LoData  output  DATA_SIZE  WriteData for the LO register.
REQ-011 SHALL have port: WrEnable  output  1  one-cycle Enable for both HI and LO registers.
REQ-012 SHALL have port: DivZero  output  1  one-cycle flag, coincident with WrEnable, divisor was 0.

Function
REQ-013 SHALL implement FSM states IDLE, BUSY, DONE.
REQ-014 IDLE with Start=1 at a rising edge SHALL latch Op/A/B, clear the iteration counter and move to BUSY; Start=0 SHALL stay in IDLE.
REQ-015 BUSY SHALL perform exactly one iteration per cycle (multiply: shift-add 1 bit; divide: restoring 1 quotient bit), then move to DONE after 32 iterations.
REQ-016 DONE SHALL last exactly one cycle with WrEnable=1 and valid HiData/LoData, then return to IDLE.
REQ-017 Latency SHALL be fixed: WrEnable high in the cycle following the 33rd rising edge after the edge that sampled Start, independent of operand values.
REQ-018 Start while Busy=1 SHALL be ignored; no queuing.
REQ-019 Back-to-back: Start high in the cycle after DONE SHALL be accepted.
REQ-020 MULT SHALL give the 64-bit two's-complement product {HiData,LoData}; MULTU SHALL give the unsigned product.
REQ-021 DIVU SHALL give LoData=quotient and HiData=remainder, unsigned.
REQ-022 DIV SHALL divide magnitudes, negate the quotient if operand signs differ, and give the remainder the dividend's sign.
REQ-023 DIV 0x80000000 / 0xFFFFFFFF SHALL give Lo=0x80000000, Hi=0, with no flag.
REQ-024 B=0 on DIV/DIVU SHALL give Lo=0xFFFFFFFF and Hi=A, with DivZero=1 in the DONE cycle, at the same latency.
REQ-025 HiData/LoData SHALL hold their last result until the next DONE, and SHALL be 0 before any result.
REQ-026 Outputs SHALL be registered; no combinational path from inputs to outputs.

Reset
REQ-027 Rst=0 SHALL asynchronously force IDLE, with Busy=0, WrEnable=0, DivZero=0, HiData=0, LoData=0, and clear the counter and internal accumulators.
REQ-028 Reset during BUSY or DONE SHALL abort the operation with no WrEnable pulse, including after Rst is released.
REQ-029 The first Start SHALL be accepted at the first rising edge with Rst=1.

Configuration
REQ-030 Macro MULDIV_DIV_EN defined SHALL compile in the divide datapath and REQ-021..REQ-024.
REQ-031 Without MULDIV_DIV_EN, Start with Op[1]=1 SHALL be ignored (stay IDLE, no WrEnable), DivZero SHALL be tied 0, and multiply behaviour SHALL be unchanged.

Verification
REQ-032 MULTU A=0xFFFFFFFF, B=0xFFFFFFFF -> Hi=0xFFFFFFFE, Lo=0x00000001, WrEnable one cycle at latency per REQ-017.
REQ-033 MULT A=0xFFFFFFFE (-2), B=3 -> Hi=0xFFFFFFFF, Lo=0xFFFFFFFA; DIV A=-7, B=2 -> Lo=0xFFFFFFFD, Hi=0xFFFFFFFF.
REQ-034 DIVU A=100, B=0 -> Lo=0xFFFFFFFF, Hi=100, DivZero=1 with WrEnable; DIV 0x80000000/-1 -> Lo=0x80000000, Hi=0.
REQ-035 Start pulsed again on cycle 5 of BUSY with different operands -> ignored; first result unchanged; Start in the cycle after DONE -> accepted.
REQ-036 Rst=0 asserted mid-BUSY (cycle 10) -> all outputs 0 immediately; no WrEnable for 40 cycles after release; next Start completes normally.
REQ-037 Build without MULDIV_DIV_EN: DIVU Start -> Busy stays 0, no WrEnable; MULTU 6x7 -> Lo=42, Hi=0.
